// File: rtl/bram_bytewrite_mp_pkg.sv
// rtl/bram_bytewrite_mp_pkg.sv - shared FSM state type and read latency (macro BRAM_BYTEWRITE_MP_OUTREG_EN)
package bram_bytewrite_mp_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } state_t;

`ifdef BRAM_BYTEWRITE_MP_OUTREG_EN
    localparam int LATENCY = 2;
`else
    localparam int LATENCY = 1;
`endif

endpackage

// File: rtl/bram_bytewrite_mp_core.sv
// rtl/bram_bytewrite_mp_core.sv - simple dual-port RAM, byte-enabled write, synchronous read
module bram_bw_core #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 8,
    parameter int COL_WIDTH  = 8
) (
    input  logic                                clk_i,
    input  logic [DATA_WIDTH/COL_WIDTH-1:0]     we_i,
    input  logic [ADDR_WIDTH-1:0]               waddr_i,
    input  logic [DATA_WIDTH-1:0]               din_i,
    input  logic [ADDR_WIDTH-1:0]               raddr_i,
    output logic [DATA_WIDTH-1:0]               dout_o
);

    localparam int NB_COL = DATA_WIDTH / COL_WIDTH;

    logic [DATA_WIDTH-1:0] mem_q [2**ADDR_WIDTH];
    logic [DATA_WIDTH-1:0] rdata_q;

    // Column-wise write; untouched columns keep their old contents.
    always_ff @(posedge clk_i) begin
        for (int c = 0; c < NB_COL; c++) begin
            if (we_i[c]) begin
                mem_q[waddr_i][c*COL_WIDTH +: COL_WIDTH] <= din_i[c*COL_WIDTH +: COL_WIDTH];
            end
        end
    end

    // Read-old synchronous read; same-cycle writes are patched in by the top-level forwarding.
    always_ff @(posedge clk_i) begin
        rdata_q <= mem_q[raddr_i];
    end

    assign dout_o = rdata_q;

endmodule

// File: rtl/bram_bytewrite_mp.sv
// rtl/bram_bytewrite_mp.sv - multi-read-port byte-write BRAM with clear sequencer (macro BRAM_BYTEWRITE_MP_OUTREG_EN)
module bram_bytewrite_mp
    import bram_bytewrite_mp_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 8,
    parameter int COL_WIDTH  = 8,
    parameter int NUM_RD     = 2
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             clr,
    output logic                             busy,
    input  logic [ADDR_WIDTH-1:0]            waddr,
    input  logic [DATA_WIDTH-1:0]            din,
    input  logic [DATA_WIDTH/COL_WIDTH-1:0]  we,
    input  logic [NUM_RD*ADDR_WIDTH-1:0]     raddr,
    output logic [NUM_RD*DATA_WIDTH-1:0]     dout
);

    localparam int NB_COL = DATA_WIDTH / COL_WIDTH;

    state_t                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   cnt_q, cnt_d;
    logic                    busy_r_q;
    logic [DATA_WIDTH-1:0]   din_q;

    logic [NB_COL-1:0]       wr_en;
    logic [ADDR_WIDTH-1:0]   wr_addr;
    logic [DATA_WIDTH-1:0]   wr_data;

    // Clear sequencer state and address counter; reset starts a fresh clear from address 0.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= CLEAR;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state: clr is only honoured in IDLE; CLEAR walks every address once then returns.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (clr) begin
                    state_d = CLEAR;
                    cnt_d   = '0;
                end
            end
            CLEAR: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == {ADDR_WIDTH{1'b1}}) begin
                    state_d = IDLE;
                end
            end
            default: state_d = CLEAR;
        endcase
    end

    assign busy = (state_q == CLEAR);

    // Write port mux: the clear write owns the array while busy, external writes are dropped.
    always_comb begin
        wr_en   = we;
        wr_addr = waddr;
        wr_data = din;
        if (busy) begin
            wr_en   = '1;
            wr_addr = cnt_q;
            wr_data = '0;
        end
    end

    // Registered write data and busy copy shared by all read ports' forwarding/masking.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            din_q    <= '0;
            busy_r_q <= 1'b1;
        end else begin
            din_q    <= wr_data;
            busy_r_q <= busy;
        end
    end

    for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
        logic [ADDR_WIDTH-1:0] ra;
        logic [DATA_WIDTH-1:0] ram_rd;
        logic [DATA_WIDTH-1:0] fwd;
        logic [NB_COL-1:0]     hit_q;

        assign ra = raddr[k*ADDR_WIDTH +: ADDR_WIDTH];

        bram_bw_core #(
            .DATA_WIDTH (DATA_WIDTH),
            .ADDR_WIDTH (ADDR_WIDTH),
            .COL_WIDTH  (COL_WIDTH)
        ) u_core (
            .clk_i   (clk),
            .we_i    (wr_en),
            .waddr_i (wr_addr),
            .din_i   (wr_data),
            .raddr_i (ra),
            .dout_o  (ram_rd)
        );

        // Per-column hit mask: which columns of this read collide with the same-cycle write.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                hit_q <= '0;
            end else begin
                hit_q <= (ra == wr_addr) ? wr_en : '0;
            end
        end

        // Write-first forwarding per column, then blank the port while a clear was in progress.
        always_comb begin
            fwd = ram_rd;
            for (int c = 0; c < NB_COL; c++) begin
                if (hit_q[c]) begin
                    fwd[c*COL_WIDTH +: COL_WIDTH] = din_q[c*COL_WIDTH +: COL_WIDTH];
                end
            end
            if (busy_r_q) begin
                fwd = '0;
            end
        end

`ifdef BRAM_BYTEWRITE_MP_OUTREG_EN
        logic [DATA_WIDTH-1:0] dout_q;

        // Optional output stage; the busy mask travels with the data it blanked.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                dout_q <= '0;
            end else begin
                dout_q <= fwd;
            end
        end

        assign dout[k*DATA_WIDTH +: DATA_WIDTH] = dout_q;
`else
        assign dout[k*DATA_WIDTH +: DATA_WIDTH] = fwd;
`endif
    end

endmodule

// File: tb/tb_bram_bytewrite_mp.sv
// tb/tb_bram_bytewrite_mp.sv - self-checking bench for bram_bytewrite_mp
module tb_bram_bytewrite_mp;
    import bram_bytewrite_mp_pkg::*;

    localparam int DW    = 32;
    localparam int AW    = 4;
    localparam int NR    = 2;
    localparam int DEPTH = 16;

    logic             clk   = 1'b0;
    logic             rst   = 1'b1;
    logic             clr   = 1'b0;
    logic             busy;
    logic [AW-1:0]    waddr = '0;
    logic [DW-1:0]    din   = '0;
    logic [3:0]       we    = '0;
    logic [NR*AW-1:0] raddr = '0;
    logic [NR*DW-1:0] dout;

    int n_tests = 0;
    int n_fail  = 0;

    logic [DW-1:0] mem_m [DEPTH];
    int            clear_left = 0;
    int            caddr      = 0;
    logic [DW-1:0] pipe_m [NR][2];
    int            bcnt;

    always #5 clk = ~clk;

    bram_bytewrite_mp #(
        .DATA_WIDTH (DW),
        .ADDR_WIDTH (AW),
        .COL_WIDTH  (8),
        .NUM_RD     (NR)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .clr   (clr),
        .busy  (busy),
        .waddr (waddr),
        .din   (din),
        .we    (we),
        .raddr (raddr),
        .dout  (dout)
    );

    task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step(input logic clr_v, input logic [3:0] we_v, input logic [AW-1:0] wa,
                        input logic [DW-1:0] d, input logic [AW-1:0] r0, input logic [AW-1:0] r1,
                        input string tag);
        logic          was_busy;
        logic [DW-1:0] e [NR];
        clr   = clr_v;
        we    = we_v;
        waddr = wa;
        din   = d;
        raddr = {r1, r0};
        @(posedge clk);
        was_busy = (clear_left > 0);
        if (clear_left > 0) begin
            mem_m[caddr] = '0;
            caddr        = (caddr + 1) % DEPTH;
            clear_left--;
        end else begin
            for (int b = 0; b < 4; b++) begin
                if (we_v[b]) mem_m[wa][b*8 +: 8] = d[b*8 +: 8];
            end
            if (clr_v) begin
                clear_left = DEPTH;
                caddr      = 0;
            end
        end
        e[0] = was_busy ? '0 : mem_m[r0];
        e[1] = was_busy ? '0 : mem_m[r1];
        for (int p = 0; p < NR; p++) begin
            pipe_m[p][1] = pipe_m[p][0];
            pipe_m[p][0] = e[p];
        end
        #1;
        check({tag, "_busy"}, 32'(busy), 32'(clear_left > 0));
        check({tag, "_dout0"}, dout[31:0], pipe_m[0][LATENCY-1]);
        check({tag, "_dout1"}, dout[63:32], pipe_m[1][LATENCY-1]);
        @(negedge clk);
    endtask

    task automatic do_reset(input int cycles);
        rst        = 1'b1;
        clear_left = DEPTH;
        caddr      = 0;
        for (int p = 0; p < NR; p++) begin
            pipe_m[p][0] = '0;
            pipe_m[p][1] = '0;
        end
        repeat (cycles) @(posedge clk);
        #1;
        check("rst_busy", 32'(busy), 32'd1);
        check("rst_dout0", dout[31:0], '0);
        check("rst_dout1", dout[63:32], '0);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic count_busy(input string tag);
        bcnt = busy ? 1 : 0;
        for (int i = 0; i < 40 && busy; i++) begin
            step(1'b1, 4'hF, 4'd2, $urandom, 4'($urandom), 4'($urandom), tag);
            if (busy) bcnt++;
        end
        check({tag, "_len"}, 32'(bcnt), 32'd16);
    endtask

    initial begin
        for (int i = 0; i < DEPTH; i++) mem_m[i] = '0;
        @(negedge clk);
        do_reset(3);
        count_busy("init_clear");

        step(1'b0, 4'h0, 4'd0, 32'h0, 4'd5, 4'd0, "rd5");
        check("rd5_zero", dout[31:0], 32'h0);

        step(1'b0, 4'hF, 4'd3, 32'hAABBCCDD, 4'd0, 4'd0, "wr3");
        step(1'b0, 4'h0, 4'd0, 32'h0, 4'd0, 4'd3, "rd3");
        check("rd3_val", dout[63:32], 32'hAABBCCDD);

        step(1'b0, 4'hF, 4'd7, 32'h11223344, 4'd0, 4'd0, "wr7");
        step(1'b0, 4'b0101, 4'd7, 32'hFFFFFFFF, 4'd7, 4'd7, "fwd7");
        check("fwd7_p0", dout[31:0], 32'h11FF33FF);
        check("fwd7_p1", dout[63:32], 32'h11FF33FF);

        step(1'b0, 4'hF, 4'd8, 32'hCAFEF00D, 4'd7, 4'd8, "fwd8");
        check("fwd8_p0", dout[31:0], 32'h11FF33FF);
        check("fwd8_p1", dout[63:32], 32'hCAFEF00D);

        step(1'b0, 4'hF, 4'd2, 32'h12345678, 4'd0, 4'd0, "wr2");
        step(1'b1, 4'h0, 4'd0, 32'h0, 4'd2, 4'd2, "clr_pulse");
        count_busy("clr_seq");
        step(1'b0, 4'h0, 4'd0, 32'h0, 4'd2, 4'd3, "rd2_after_clr");
        check("rd2_zero", dout[31:0], 32'h0);
        check("rd3_zero", dout[63:32], 32'h0);

        for (int a = 0; a < DEPTH; a++) step(1'b0, 4'hF, 4'(a), $urandom, 4'(a), 4'(a), "fill");
        step(1'b1, 4'h0, 4'd0, 32'h0, 4'd0, 4'd0, "clr_mid");
        for (int i = 0; i < 9; i++) step(1'b0, 4'h0, 4'd0, 32'h0, 4'd0, 4'd0, "clr_run");
        do_reset(2);
        count_busy("rst_mid");
        for (int a = 0; a < DEPTH; a++) begin
            step(1'b0, 4'h0, 4'd0, 32'h0, 4'(a), 4'(DEPTH-1-a), "post_rst");
            check("post_rst_zero", dout[31:0] | dout[63:32], 32'h0);
        end

        for (int i = 0; i < 400; i++) begin
            step(($urandom_range(0, 49) == 0), 4'($urandom), 4'($urandom), $urandom,
                 4'($urandom), 4'($urandom), "rand");
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
